imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for the instruction memory. It receives a byte stream over
//  a valid/ready handshake, for example from a UART receiver, and assembles
//  little-endian 32-bit words. It writes them to consecutive word addresses
//  starting at 0 and holds the core in reset until the load completes.
//  It sits between the byte source and the instruction memory's write port.
// PARAMETERS
//  DEPTH   64  instruction memory size in words
//  ADDR_W  6   word address width; must equal clog2(DEPTH)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       one-cycle pulse that arms a new load
//  rx_data    in   8       incoming byte
//  rx_valid   in   1       rx_data is valid
//  rx_ready   out  1       loader accepts a byte this cycle
//  we         out  1       instruction memory write strobe, one cycle per word
//  waddr      out  ADDR_W  word address of the write
//  wdata      out  32      word to write
//  busy       out  1       a load is in progress
//  done       out  1       last load completed without error
//  err        out  1       last load rejected: length > DEPTH
//  core_hold  out  1       keeps the core in reset; high unless state is DONE
// BEHAVIOUR
//  Reset values: state IDLE; rx_ready=0, we=0, waddr=0, wdata=0, busy=0,
//   done=0, err=0, core_hold=1. Reset does not clear the instruction memory.
//  Byte transfer: a byte is accepted only when rx_valid && rx_ready.
//   rx_ready=1 only in states LEN0, LEN1 and DATA.
//  Frame format: 16-bit little-endian word count N (LEN0 = low byte,
//   LEN1 = high byte), then 4*N payload bytes, least significant byte first.
//  IDLE: start -> LEN0; busy=1.
//  LEN0: byte accepted -> len[7:0]; go to LEN1.
//  LEN1: byte accepted -> len[15:8]; evaluate the full count:
//   N==0      -> DONE (no writes).
//   N>DEPTH   -> ERR (no writes).
//   otherwise -> DATA, with word index=0 and byte counter=0.
//  DATA: each accepted byte goes into lane [8*bc +: 8] of the assembly register;
//   bc increments and wraps 3->0.
//   When the 4th byte is accepted, on the next cycle: we=1 for exactly one
//    cycle, waddr=word index, wdata=assembled word. The index then increments.
//   rx_ready stays high during the write cycle. The assembly register is
//    separate from the wdata register, so the next word's first byte may be
//    accepted while the previous word is written.
//   After the write of word N-1 -> DONE. The final we pulse occurs in the
//    cycle before busy falls.
//  DONE: done=1, busy=0, core_hold=0. A start pulse -> LEN0, done=0,
//   core_hold=1.
//  ERR: err=1, busy=0, core_hold=1. A start pulse -> LEN0, err=0.
//  start is ignored in LEN0, LEN1 and DATA.
//  Latency: last payload byte accepted at cycle t -> we at t+1 -> done=1 and
//   busy=0 at t+2.
//  waddr and wdata hold their last values when we=0. The word index never
//   exceeds DEPTH-1 because N<=DEPTH.
//  Reset mid-load: return to IDLE immediately with reset values. Words already
//   written remain in memory. Partial words are discarded.
//  Throughput: one byte per cycle sustained. rx_valid gaps of any length are
//   tolerated and do not change lane order.
// TESTING
//  1. Reset -> core_hold=1, rx_ready=0, we=0, done=0, err=0.
//  2. start; bytes 02 00 13 00 00 00 B3 00 50 00 ->
//     we at waddr 0 with 0x00000013, then at waddr 1 with 0x005000B3;
//     done=1 and core_hold=0 two cycles after the last byte.
//  3. start; length bytes 41 00 (N=65, DEPTH=64) -> no we pulse; err=1,
//     core_hold=1. A new start clears err.
//  4. start; length 00 00 -> done=1 with zero writes.
//  5. N=64 with random rx_valid gaps -> exactly 64 we pulses on addresses
//     0..63, and data matches the byte stream.
//  6. Reset asserted after the 6th payload byte -> IDLE immediately;
//     word 0 stays written; a new start reloads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a length-prefixed little-endian byte stream over valid/ready,
// assembles 32-bit words and writes them to consecutive word addresses
// starting at 0. The core is held in reset until a load completes cleanly.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_hold
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    DONE,
    ERR
  } state_t;

  state_t              state;
  logic [7:0]          len_lo;    // low byte of the word count
  logic [15:0]         len;       // full word count N
  logic [ADDR_W-1:0]   idx;       // index of the next word to write
  logic [1:0]          bc;        // byte lane within the word being assembled
  logic [23:0]         asm_q;     // lanes 0..2; lane 3 goes straight to wdata
  logic                last_wr;   // the write in flight is word N-1

  logic                accept;
  logic [15:0]         len_full;
  logic [15:0]         idx_ext;

  assign accept   = rx_valid && rx_ready;
  assign len_full = {rx_data, len_lo};
  assign idx_ext  = {{(16-ADDR_W){1'b0}}, idx};

  // Load sequencer: parses the frame, assembles words and drives every output
  // from a register so the memory port and core_hold are glitch-free.
  // NOTE: every state/output register here uses <= so all updates land
  // together at the clock edge; mixing in = would make results order-dependent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_lo    <= '0;
      len       <= '0;
      idx       <= '0;
      bc        <= '0;
      asm_q     <= '0;
      last_wr   <= 1'b0;
      rx_ready  <= 1'b0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LEN0;
            busy     <= 1'b1;
            rx_ready <= 1'b1;
          end
        end

        LEN0: begin
          if (accept) begin
            len_lo <= rx_data;
            state  <= LEN1;
          end
        end

        LEN1: begin
          if (accept) begin
            len <= len_full;
            if (len_full == 16'd0) begin
              // Empty image: nothing to write, release the core at once.
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              core_hold <= 1'b0;
              rx_ready  <= 1'b0;
            end else if (len_full > 16'(DEPTH)) begin
              // Image larger than the memory: reject before touching it.
              state    <= ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              rx_ready <= 1'b0;
            end else begin
              state   <= DATA;
              idx     <= '0;
              bc      <= '0;
              last_wr <= 1'b0;
            end
          end
        end

        DATA: begin
          if (last_wr) begin
            // Final word is being written this cycle; finish on the next edge.
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            core_hold <= 1'b0;
            rx_ready  <= 1'b0;
            last_wr   <= 1'b0;
          end else if (accept) begin
            bc <= bc + 2'd1;
            if (bc == 2'd3) begin
              // Fourth byte completes the word; wdata is separate from asm_q
              // so the next word can start assembling during the write.
              we      <= 1'b1;
              waddr   <= idx;
              wdata   <= {rx_data, asm_q};
              idx     <= idx + ADDR_W'(1);
              last_wr <= (idx_ext == len - 16'd1);
            end else begin
              asm_q[8*bc +: 8] <= rx_data;
            end
          end
        end

        DONE: begin
          if (start) begin
            state     <= LEN0;
            done      <= 1'b0;
            core_hold <= 1'b1;
            busy      <= 1'b1;
            rx_ready  <= 1'b1;
          end
        end

        ERR: begin
          if (start) begin
            state    <= LEN0;
            err      <= 1'b0;
            busy     <= 1'b1;
            rx_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a scoreboard queue holds the expected
// writes, pushed as payload is driven and popped by a write-port monitor.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_hold;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .core_hold (core_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] mem [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  int          we_count = 0;

  // Write-port monitor: models the instruction memory and scores each write.
  always @(negedge clk) begin
    if (we) begin
      we_count++;
      mem[waddr] = wdata;
      check("we_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("waddr", 32'(waddr), 32'(mon_e.addr));
        check("wdata", wdata, mon_e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All driving tasks start and end 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit accepted;
    rx_valid = 1'b0;
    repeat ($urandom_range(max_gap, 0)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (rx_ready) accepted = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    check("rx_accept", 32'(accepted), 32'd1);
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input int max_gap);
    wr_t e;
    e.addr = ADDR_W'(idx);
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  int          base;
  logic [31:0] w;
  logic [31:0] w0;
  logic [7:0]  frame2 [10];

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    frame2 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};
    repeat (2) tick();

    // 1. Reset state
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_rx_ready",  32'(rx_ready),  32'd0);
    check("rst_we",        32'(we),        32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    reset = 1'b0;
    tick();

    // 2. Two-word load with exact completion latency
    pulse_start();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_rx_ready", 32'(rx_ready), 32'd1);
    base = we_count;
    exp_q.push_back('{addr: 6'd0, data: 32'h0000_0013});
    exp_q.push_back('{addr: 6'd1, data: 32'h0050_00B3});
    for (int i = 0; i < 10; i++) send_byte(frame2[i], 0);
    check("t2_we_after_last", 32'(we), 32'd1);
    check("t2_done_early", 32'(done), 32'd0);
    check("t2_busy_during_we", 32'(busy), 32'd1);
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy_fall", 32'(busy), 32'd0);
    check("t2_core_hold", 32'(core_hold), 32'd0);
    check("t2_we_count", 32'(we_count - base), 32'd2);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3. Oversized length is rejected, a new start clears err
    pulse_start();
    check("t3_done_cleared", 32'(done), 32'd0);
    check("t3_core_hold_on", 32'(core_hold), 32'd1);
    base = we_count;
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    check("t3_err", 32'(err), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_core_hold", 32'(core_hold), 32'd1);
    check("t3_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) tick();
    check("t3_no_writes", 32'(we_count - base), 32'd0);
    pulse_start();
    check("t3_err_cleared", 32'(err), 32'd0);
    check("t3_busy_again", 32'(busy), 32'd1);

    // 4. Zero-length image
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_core_hold", 32'(core_hold), 32'd0);
    repeat (2) tick();
    check("t4_no_writes", 32'(we_count - base), 32'd0);

    // 5. Full-depth image with random valid gaps; a stray start mid-load
    pulse_start();
    base = we_count;
    send_byte(8'h40, 2);
    send_byte(8'h00, 2);
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      exp_mem[i] = w;
      send_word(i, w, 3);
      if (i == 10) pulse_start();
    end
    wait_done("t5_done");
    check("t5_we_count", 32'(we_count - base), 32'(DEPTH));
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) check("t5_mem", mem[i], exp_mem[i]);

    // 6. Reset after the 6th payload byte, then reload
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    w0 = 32'hCAFE_0001;
    send_word(0, w0, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rx_ready", 32'(rx_ready), 32'd0);
    check("t6_core_hold", 32'(core_hold), 32'd1);
    check("t6_we", 32'(we), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_word0_kept", mem[0], w0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(0, 32'h1234_5678, 2);
    send_word(1, 32'h9ABC_DEF0, 2);
    wait_done("t6_done_reload");
    check("t6_mem0", mem[0], 32'h1234_5678);
    check("t6_mem1", mem[1], 32'h9ABC_DEF0);
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
